// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner ids, access size codes
// and the latched data-side request payload.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Size codes shared with data_cache
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } data_req_t;

  localparam int DATA_REQ_W = $bits(data_req_t);

  // Data has priority unless the streak limit is hit while inst waits.
  function automatic owner_t pick_owner(input logic inst_pending,
                                        input logic data_pending,
                                        input logic streak_full);
    if (inst_pending && (!data_pending || streak_full))
      return OWN_INST;
    return OWN_DATA;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-request memory port between the arbiter (master) and the AXI bridge (slave).
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_wr;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_req_slot.sv
// One-entry request holder: captures the payload on a set pulse and keeps a pending
// flag until the arbiter grants (clears) it.
module req_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             pending,
  output logic [WIDTH-1:0] payload
);

  logic             pending_reg;
  logic [WIDTH-1:0] payload_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      payload_reg <= '0;
    end else if (set) begin
      pending_reg <= 1'b1;
      payload_reg <= din;
    end else if (clear) begin
      pending_reg <= 1'b0;
    end
  end

  assign pending = pending_reg;
  assign payload = payload_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between inst_cache and data_cache: latches request pulses,
// grants with data priority plus an anti-starvation streak limit, routes the response back.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_interface_call_begin,
  input  logic [31:0]          inst_interface_addr,
  output logic                 inst_interface_return_ready,
  output logic [31:0]          inst_interface_rdata,
  input  logic                 data_interface_call_begin,
  input  logic                 write_enable,
  input  logic [2:0]           read_size,
  input  logic [2:0]           write_size,
  input  logic [31:0]          data_interface_raddr,
  input  logic [31:0]          data_interface_waddr,
  input  logic [31:0]          data_interface_wdata,
  output logic                 data_interface_return_ready,
  output logic [31:0]          data_interface_rdata,
  mem_port_arbiter_if.master   mem,
  output logic                 protocol_err
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  state_t              state_reg;
  owner_t              owner_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic                mem_req_reg, mem_wr_reg;
  logic [2:0]          mem_size_reg;
  logic [31:0]         mem_addr_reg, mem_wdata_reg;
  logic                inst_ready_reg, data_ready_reg, protocol_err_reg;
  logic [31:0]         inst_rdata_reg, data_rdata_reg;

  logic        inst_pending, data_pending;
  logic [31:0] inst_slot_addr;
  data_req_t   data_in, data_slot;
  logic        inst_busy, data_busy, inst_err, data_err;
  logic        grant_valid, streak_full, inst_clear, data_clear;
  owner_t      grant_owner;

  // A transaction stops counting as in flight in the cycle its response arrives,
  // so the owner may issue its next request back-to-back with the response.
  assign inst_busy = (owner_reg == OWN_INST) &&
                     ((state_reg == ST_REQ) || (state_reg == ST_WAIT && !mem.mem_data_ok));
  assign data_busy = (owner_reg == OWN_DATA) &&
                     ((state_reg == ST_REQ) || (state_reg == ST_WAIT && !mem.mem_data_ok));
  assign inst_err  = inst_interface_call_begin && (inst_pending || inst_busy);
  assign data_err  = data_interface_call_begin && (data_pending || data_busy);

  assign data_in.wr    = write_enable;
  assign data_in.size  = write_enable ? write_size : read_size;
  assign data_in.addr  = write_enable ? data_interface_waddr : data_interface_raddr;
  assign data_in.wdata = data_interface_wdata;

  assign streak_full = (streak_reg == STREAK_W'(MAX_DATA_STREAK));
  assign grant_valid = (state_reg == ST_IDLE) && (inst_pending || data_pending);
  assign grant_owner = pick_owner(inst_pending, data_pending, streak_full);
  assign inst_clear  = grant_valid && (grant_owner == OWN_INST);
  assign data_clear  = grant_valid && (grant_owner == OWN_DATA);

  req_slot #(.WIDTH(32)) inst_slot (
    .clk     (clk),
    .reset   (reset),
    .set     (inst_interface_call_begin && !inst_err),
    .clear   (inst_clear),
    .din     (inst_interface_addr),
    .pending (inst_pending),
    .payload (inst_slot_addr)
  );

  req_slot #(.WIDTH(DATA_REQ_W)) data_slot_i (
    .clk     (clk),
    .reset   (reset),
    .set     (data_interface_call_begin && !data_err),
    .clear   (data_clear),
    .din     (data_in),
    .pending (data_pending),
    .payload (data_slot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      owner_reg        <= OWN_INST;
      streak_reg       <= '0;
      mem_req_reg      <= 1'b0;
      mem_wr_reg       <= 1'b0;
      mem_size_reg     <= 3'd0;
      mem_addr_reg     <= 32'd0;
      mem_wdata_reg    <= 32'd0;
      inst_ready_reg   <= 1'b0;
      inst_rdata_reg   <= 32'd0;
      data_ready_reg   <= 1'b0;
      data_rdata_reg   <= 32'd0;
      protocol_err_reg <= 1'b0;
    end else begin
      inst_ready_reg <= 1'b0;
      inst_rdata_reg <= 32'd0;
      data_ready_reg <= 1'b0;
      data_rdata_reg <= 32'd0;

      if (inst_err || data_err)
        protocol_err_reg <= 1'b1;

      if (!inst_pending || inst_clear)
        streak_reg <= '0;
      else if (data_clear && !streak_full)
        streak_reg <= streak_reg + 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_reg   <= grant_owner;
            state_reg   <= ST_REQ;
            mem_req_reg <= 1'b1;
            if (grant_owner == OWN_INST) begin
              mem_wr_reg    <= 1'b0;
              mem_size_reg  <= SIZE_WORD;
              mem_addr_reg  <= inst_slot_addr;
              mem_wdata_reg <= 32'd0;
            end else begin
              mem_wr_reg    <= data_slot.wr;
              mem_size_reg  <= data_slot.size;
              mem_addr_reg  <= data_slot.addr;
              mem_wdata_reg <= data_slot.wdata;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_addr_ok) begin
            mem_req_reg <= 1'b0;
            state_reg   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem.mem_data_ok) begin
            state_reg <= ST_IDLE;
            if (owner_reg == OWN_INST) begin
              inst_ready_reg <= 1'b1;
              inst_rdata_reg <= mem.mem_rdata;
            end else begin
              data_ready_reg <= 1'b1;
              data_rdata_reg <= mem_wr_reg ? 32'd0 : mem.mem_rdata;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_wr    = mem_wr_reg;
  assign mem.mem_size  = mem_size_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;

  assign inst_interface_return_ready = inst_ready_reg;
  assign inst_interface_rdata        = inst_rdata_reg;
  assign data_interface_return_ready = data_ready_reg;
  assign data_interface_rdata        = data_rdata_reg;
  assign protocol_err                = protocol_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays both caches and the AXI bridge.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_interface_call_begin;
  logic [31:0] inst_interface_addr;
  logic        inst_interface_return_ready;
  logic [31:0] inst_interface_rdata;
  logic        data_interface_call_begin;
  logic        write_enable;
  logic [2:0]  read_size, write_size;
  logic [31:0] data_interface_raddr, data_interface_waddr, data_interface_wdata;
  logic        data_interface_return_ready;
  logic [31:0] data_interface_rdata;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if mem_bus ();

  mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .inst_interface_call_begin   (inst_interface_call_begin),
    .inst_interface_addr         (inst_interface_addr),
    .inst_interface_return_ready (inst_interface_return_ready),
    .inst_interface_rdata        (inst_interface_rdata),
    .data_interface_call_begin   (data_interface_call_begin),
    .write_enable                (write_enable),
    .read_size                   (read_size),
    .write_size                  (write_size),
    .data_interface_raddr        (data_interface_raddr),
    .data_interface_waddr        (data_interface_waddr),
    .data_interface_wdata        (data_interface_wdata),
    .data_interface_return_ready (data_interface_return_ready),
    .data_interface_rdata        (data_interface_rdata),
    .mem                         (mem_bus),
    .protocol_err                (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inst(input logic [31:0] a);
    inst_interface_addr       = a;
    inst_interface_call_begin = 1'b1;
    tick();
    inst_interface_call_begin = 1'b0;
  endtask

  task automatic set_data(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
    write_enable         = we;
    read_size            = we ? SIZE_BYTE : sz;
    write_size           = we ? sz : SIZE_BYTE;
    data_interface_raddr = we ? 32'hFFFF_0000 : a;
    data_interface_waddr = we ? a : 32'hEEEE_0000;
    data_interface_wdata = wd;
  endtask

  // Accept the request shown now, answer one cycle later; optionally re-issue a data
  // load in the response cycle. Returns in the cycle the return pulse is visible.
  task automatic serve_now(input logic [31:0] rd, input logic repulse, input logic [31:0] re_addr);
    mem_bus.mem_addr_ok = 1'b1;
    tick();
    mem_bus.mem_addr_ok = 1'b0;
    chk("req_drop_after_addr_ok", {31'd0, mem_bus.mem_req}, 32'd0);
    mem_bus.mem_data_ok = 1'b1;
    mem_bus.mem_rdata   = rd;
    if (repulse) begin
      set_data(1'b0, SIZE_WORD, re_addr, 32'd0);
      data_interface_call_begin = 1'b1;
    end
    tick();
    mem_bus.mem_data_ok       = 1'b0;
    mem_bus.mem_rdata         = 32'd0;
    data_interface_call_begin = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inst_interface_call_begin = 1'b0;
    inst_interface_addr       = 32'd0;
    data_interface_call_begin = 1'b0;
    set_data(1'b0, SIZE_WORD, 32'd0, 32'd0);
    mem_bus.mem_addr_ok = 1'b0;
    mem_bus.mem_data_ok = 1'b0;
    mem_bus.mem_rdata   = 32'd0;
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    chk("rst_inst_ready", {31'd0, inst_interface_return_ready}, 32'd0);
    chk("rst_data_ready", {31'd0, data_interface_return_ready}, 32'd0);
    chk("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: lone inst fetch
    pulse_inst(32'h0000_1000);
    chk("s1_req_t1", {31'd0, mem_bus.mem_req}, 32'd0);
    tick();
    chk("s1_req_t2", {31'd0, mem_bus.mem_req}, 32'd1);
    chk("s1_addr", mem_bus.mem_addr, 32'h0000_1000);
    chk("s1_wr", {31'd0, mem_bus.mem_wr}, 32'd0);
    chk("s1_size", {29'd0, mem_bus.mem_size}, {29'd0, SIZE_WORD});
    mem_bus.mem_addr_ok = 1'b1;
    tick();
    mem_bus.mem_addr_ok = 1'b0;
    chk("s1_req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
    tick();
    tick();
    mem_bus.mem_data_ok = 1'b1;
    mem_bus.mem_rdata   = 32'h2402_0001;
    tick();
    mem_bus.mem_data_ok = 1'b0;
    mem_bus.mem_rdata   = 32'd0;
    chk("s1_inst_ready", {31'd0, inst_interface_return_ready}, 32'd1);
    chk("s1_inst_rdata", inst_interface_rdata, 32'h2402_0001);
    chk("s1_data_silent", {31'd0, data_interface_return_ready}, 32'd0);
    tick();
    chk("s1_inst_ready_once", {31'd0, inst_interface_return_ready}, 32'd0);
    chk("s1_inst_rdata_zero", inst_interface_rdata, 32'd0);

    // 2: simultaneous inst + data load, data first
    set_data(1'b0, SIZE_WORD, 32'h0000_2000, 32'd0);
    inst_interface_addr       = 32'h0000_0100;
    inst_interface_call_begin = 1'b1;
    data_interface_call_begin = 1'b1;
    tick();
    inst_interface_call_begin = 1'b0;
    data_interface_call_begin = 1'b0;
    tick();
    chk("s2_first_req", {31'd0, mem_bus.mem_req}, 32'd1);
    chk("s2_first_addr", mem_bus.mem_addr, 32'h0000_2000);
    serve_now(32'h1111_2222, 1'b0, 32'd0);
    chk("s2_data_ready", {31'd0, data_interface_return_ready}, 32'd1);
    chk("s2_data_rdata", data_interface_rdata, 32'h1111_2222);
    chk("s2_inst_not_ready", {31'd0, inst_interface_return_ready}, 32'd0);
    chk("s2_gap_req", {31'd0, mem_bus.mem_req}, 32'd0);
    tick();
    chk("s2_inst_req", {31'd0, mem_bus.mem_req}, 32'd1);
    chk("s2_inst_addr", mem_bus.mem_addr, 32'h0000_0100);
    serve_now(32'h3333_4444, 1'b0, 32'd0);
    chk("s2_inst_ready", {31'd0, inst_interface_return_ready}, 32'd1);
    chk("s2_inst_rdata", inst_interface_rdata, 32'h3333_4444);
    chk("s2_data_quiet", {31'd0, data_interface_return_ready}, 32'd0);
    tick();

    // 3: streak limit of 4 data grants while inst waits
    set_data(1'b0, SIZE_WORD, 32'h0000_0600, 32'd0);
    inst_interface_addr       = 32'h0000_0500;
    inst_interface_call_begin = 1'b1;
    data_interface_call_begin = 1'b1;
    tick();
    inst_interface_call_begin = 1'b0;
    data_interface_call_begin = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s3_data_grant%0d_req", k), {31'd0, mem_bus.mem_req}, 32'd1);
      chk($sformatf("s3_data_grant%0d_addr", k), mem_bus.mem_addr, 32'h0000_0600);
      serve_now(32'h0000_6000 + k, 1'b1, 32'h0000_0600);
      chk($sformatf("s3_data_ready%0d", k), {31'd0, data_interface_return_ready}, 32'd1);
      chk($sformatf("s3_data_rdata%0d", k), data_interface_rdata, 32'h0000_6000 + k);
      tick();
    end
    chk("s3_fifth_req", {31'd0, mem_bus.mem_req}, 32'd1);
    chk("s3_fifth_is_inst", mem_bus.mem_addr, 32'h0000_0500);
    serve_now(32'h0000_A5A5, 1'b0, 32'd0);
    chk("s3_inst_ready", {31'd0, inst_interface_return_ready}, 32'd1);
    chk("s3_inst_rdata", inst_interface_rdata, 32'h0000_A5A5);
    tick();
    chk("s3_data_after_inst", mem_bus.mem_addr, 32'h0000_0600);
    serve_now(32'h0000_6666, 1'b0, 32'd0);
    chk("s3_last_data_ready", {31'd0, data_interface_return_ready}, 32'd1);
    chk("s3_no_protocol_err", {31'd0, protocol_err}, 32'd0);
    tick();

    // 4: store with addr_ok held off 5 cycles
    set_data(1'b1, SIZE_WORD, 32'h0000_3000, 32'hDEAD_BEEF);
    data_interface_call_begin = 1'b1;
    tick();
    data_interface_call_begin = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s4_req_c%0d", i), {31'd0, mem_bus.mem_req}, 32'd1);
      chk($sformatf("s4_addr_c%0d", i), mem_bus.mem_addr, 32'h0000_3000);
      chk($sformatf("s4_wdata_c%0d", i), mem_bus.mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("s4_wr_c%0d", i), {31'd0, mem_bus.mem_wr}, 32'd1);
      chk($sformatf("s4_size_c%0d", i), {29'd0, mem_bus.mem_size}, {29'd0, SIZE_WORD});
      tick();
    end
    serve_now(32'h5555_5555, 1'b0, 32'd0);
    chk("s4_store_ready", {31'd0, data_interface_return_ready}, 32'd1);
    chk("s4_store_rdata", data_interface_rdata, 32'd0);
    set_data(1'b0, SIZE_WORD, 32'd0, 32'd0);
    tick();

    // 5: reset while waiting; late response must be dropped
    pulse_inst(32'h0000_0700);
    tick();
    chk("s5_req", {31'd0, mem_bus.mem_req}, 32'd1);
    mem_bus.mem_addr_ok = 1'b1;
    tick();
    mem_bus.mem_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_req_after_reset", {31'd0, mem_bus.mem_req}, 32'd0);
    mem_bus.mem_data_ok = 1'b1;
    mem_bus.mem_rdata   = 32'h0000_0077;
    tick();
    mem_bus.mem_data_ok = 1'b0;
    mem_bus.mem_rdata   = 32'd0;
    chk("s5_no_inst_ready", {31'd0, inst_interface_return_ready}, 32'd0);
    chk("s5_no_data_ready", {31'd0, data_interface_return_ready}, 32'd0);
    tick();
    chk("s5_idle_req", {31'd0, mem_bus.mem_req}, 32'd0);
    pulse_inst(32'h0000_0800);
    tick();
    chk("s5_new_req", {31'd0, mem_bus.mem_req}, 32'd1);
    chk("s5_new_addr", mem_bus.mem_addr, 32'h0000_0800);
    serve_now(32'h8888_8888, 1'b0, 32'd0);
    chk("s5_new_ready", {31'd0, inst_interface_return_ready}, 32'd1);
    chk("s5_new_rdata", inst_interface_rdata, 32'h8888_8888);
    tick();

    // 6: second inst pulse while inst in flight
    chk("s6_err_clear", {31'd0, protocol_err}, 32'd0);
    pulse_inst(32'h0000_0900);
    tick();
    chk("s6_req", {31'd0, mem_bus.mem_req}, 32'd1);
    mem_bus.mem_addr_ok = 1'b1;
    tick();
    mem_bus.mem_addr_ok = 1'b0;
    pulse_inst(32'h0000_0904);
    chk("s6_err_set", {31'd0, protocol_err}, 32'd1);
    mem_bus.mem_data_ok = 1'b1;
    mem_bus.mem_rdata   = 32'h0000_0099;
    tick();
    mem_bus.mem_data_ok = 1'b0;
    mem_bus.mem_rdata   = 32'd0;
    chk("s6_inst_ready", {31'd0, inst_interface_return_ready}, 32'd1);
    chk("s6_inst_rdata", inst_interface_rdata, 32'h0000_0099);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("s6_no_req_c%0d", i), {31'd0, mem_bus.mem_req}, 32'd0);
      chk($sformatf("s6_no_ready_c%0d", i), {31'd0, inst_interface_return_ready}, 32'd0);
    end
    chk("s6_err_sticky", {31'd0, protocol_err}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_err_reset", {31'd0, protocol_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
